// File: rtl/tetris_pkg.sv
// Shared constants and types for the Tetris display path: grid geometry, palette,
// and the stage-1 pixel classification record.
package tetris_pkg;

    localparam int unsigned GRID_W = 10;
    localparam int unsigned GRID_H = 20;

    localparam logic [11:0] COL_CYAN   = 12'h0FF;
    localparam logic [11:0] COL_RED    = 12'hF00;
    localparam logic [11:0] COL_GRID   = 12'h333;
    localparam logic [11:0] COL_BORDER = 12'hFFF;
    localparam logic [11:0] COL_BLACK  = 12'h000;

    typedef struct packed {
        logic       active;
        logic       in_grid;
        logic       border;
        logic       gridline;
        logic [4:0] row;
        logic [3:0] col;
    } stage1_t;

    // Flat bit index into display_array; only meaningful for in-grid cells.
    function automatic logic [7:0] cell_index(input logic [4:0] row, input logic [3:0] col);
        return ({3'b000, row} * 8'd10) + {4'b0000, col};
    endfunction

endpackage

// File: rtl/tetris_grid_renderer_if.sv
// Game-state and pixel-timing bundle between the game FSM/VGA timing (master)
// and the grid renderer (slave).
interface tetris_grid_renderer_if;

    logic [199:0] display_array;
    logic         gameover;
    logic         frame_start;
    logic [9:0]   hcount;
    logic [9:0]   vcount;
    logic         active;
    logic [11:0]  pixel_rgb;
    logic         pixel_valid;

    modport master (
        output display_array, gameover, frame_start, hcount, vcount, active,
        input  pixel_rgb, pixel_valid
    );

    modport slave (
        input  display_array, gameover, frame_start, hcount, vcount, active,
        output pixel_rgb, pixel_valid
    );

endinterface

// File: rtl/tetris_grid_renderer.sv
// Two-stage pixel renderer for the Tetris grid: per-frame snapshot of the board,
// border/gridline drawing, and a blinking stack after game over.
module tetris_grid_renderer
    import tetris_pkg::*;
#(
    parameter int H_ORIGIN  = 240,
    parameter int V_ORIGIN  = 80,
    parameter int CELL_LOG2 = 4
) (
    input logic                   clk,
    input logic                   reset,
    tetris_grid_renderer_if.slave bus
);

    localparam logic signed [10:0] H_OFF     = 11'(H_ORIGIN);
    localparam logic signed [10:0] V_OFF     = 11'(V_ORIGIN);
    localparam logic signed [10:0] GRID_PX_W = 11'(GRID_W << CELL_LOG2);
    localparam logic signed [10:0] GRID_PX_H = 11'(GRID_H << CELL_LOG2);
    localparam logic signed [10:0] NEG_ONE   = -11'sd1;

    logic [199:0] snap_q;
    logic         go_snap_q;
    logic [5:0]   blink_cnt_q;
    stage1_t      s1_q, s1_d;
    logic [11:0]  rgb_q, rgb_d;
    logic         valid_q;

    logic signed [10:0] dx, dy;
    logic               dx_edge, dy_edge, dx_span, dy_span;

    always_comb begin
        dx = $signed({1'b0, bus.hcount}) - H_OFF;
        dy = $signed({1'b0, bus.vcount}) - V_OFF;

        // Border ring sits one pixel outside the grid on every side, corners included.
        dx_edge = (dx == NEG_ONE) || (dx == GRID_PX_W);
        dy_edge = (dy == NEG_ONE) || (dy == GRID_PX_H);
        dx_span = (dx >= NEG_ONE) && (dx <= GRID_PX_W);
        dy_span = (dy >= NEG_ONE) && (dy <= GRID_PX_H);

        s1_d          = '0;
        s1_d.active   = bus.active;
        s1_d.in_grid  = (dx >= 0) && (dx < GRID_PX_W) && (dy >= 0) && (dy < GRID_PX_H);
        s1_d.border   = (dx_edge && dy_span) || (dy_edge && dx_span);
        s1_d.col      = dx[CELL_LOG2 +: 4];
        s1_d.row      = dy[CELL_LOG2 +: 5];
        s1_d.gridline = (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);
    end

    logic [7:0] idx;
    logic       occ;
    logic       hide;

    always_comb begin
        idx  = cell_index(s1_q.row, s1_q.col);
        occ  = s1_q.in_grid && snap_q[idx];
        hide = go_snap_q & blink_cnt_q[5];

        rgb_d = COL_BLACK;
        if (!s1_q.active) begin
            rgb_d = COL_BLACK;
        end else if (s1_q.border) begin
            rgb_d = COL_BORDER;
        end else if (occ && !hide) begin
            rgb_d = go_snap_q ? COL_RED : COL_CYAN;
        end else if (s1_q.in_grid && s1_q.gridline) begin
            rgb_d = COL_GRID;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q      <= '0;
            go_snap_q   <= 1'b0;
            blink_cnt_q <= '0;
            s1_q        <= '0;
            rgb_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            if (bus.frame_start) begin
                snap_q      <= bus.display_array;
                go_snap_q   <= bus.gameover;
                blink_cnt_q <= bus.gameover ? blink_cnt_q + 6'd1 : '0;
            end
            s1_q    <= s1_d;
            rgb_q   <= rgb_d;
            valid_q <= s1_q.active;
        end
    end

    assign bus.pixel_rgb   = rgb_q;
    assign bus.pixel_valid = valid_q;

endmodule

// File: tb/tb_tetris_grid_renderer.sv
// Directed bench for tetris_grid_renderer: a frame-level model predicts every
// output pixel, and literal expectations pin the model to hand-computed values.
module tb_tetris_grid_renderer;

    logic clk;
    logic reset;

    tetris_grid_renderer_if bus ();

    tetris_grid_renderer #(
        .H_ORIGIN (240),
        .V_ORIGIN (80),
        .CELL_LOG2(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    typedef struct packed {
        logic        valid;
        logic [11:0] rgb;
    } px_t;

    // Colour rules stated directly on screen coordinates with 16-px cells.
    function automatic logic [11:0] exp_colour(input int h, input int v, input bit a,
                                               input logic [199:0] board, input bit go,
                                               input int cnt);
        int  dx, dy;
        bit  brd, ing;
        dx = h - 240;
        dy = v - 80;
        if (!a) return 12'h000;
        brd = ((dx == -1 || dx == 160) && dy >= -1 && dy <= 320) ||
              ((dy == -1 || dy == 320) && dx >= -1 && dx <= 160);
        if (brd) return 12'hFFF;
        ing = dx >= 0 && dx < 160 && dy >= 0 && dy < 320;
        if (!ing) return 12'h000;
        if (board[(dy / 16) * 10 + dx / 16] && !(go && cnt >= 32))
            return go ? 12'hF00 : 12'h0FF;
        if (dx % 16 == 0 || dy % 16 == 0) return 12'h333;
        return 12'h000;
    endfunction

    logic [199:0] m_snap;
    bit           m_go;
    int           m_cnt;
    px_t          exp_s1, exp_out;
    bit           armed = 1'b0;

    always @(posedge clk) begin : model
        logic [199:0] n_snap;
        bit           n_go;
        int           n_cnt;
        if (reset) begin
            m_snap  <= '0;
            m_go    <= 1'b0;
            m_cnt   <= 0;
            exp_s1  <= '0;
            exp_out <= '0;
            armed   <= 1'b1;
        end else begin
            n_snap = m_snap;
            n_go   = m_go;
            n_cnt  = m_cnt;
            if (bus.frame_start) begin
                n_snap = bus.display_array;
                n_go   = bus.gameover;
                n_cnt  = bus.gameover ? (m_cnt + 1) % 64 : 0;
            end
            m_snap  <= n_snap;
            m_go    <= n_go;
            m_cnt   <= n_cnt;
            exp_out <= exp_s1;
            exp_s1  <= '{valid: bus.active,
                         rgb: exp_colour(int'(bus.hcount), int'(bus.vcount), bus.active,
                                         n_snap, n_go, n_cnt)};
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            total++;
            if (bus.pixel_rgb === exp_out.rgb && bus.pixel_valid === exp_out.valid) begin
                passes++;
            end else begin
                $display("FAIL pipe t=%0t: got rgb=%h valid=%b, expected rgb=%h valid=%b",
                         $time, bus.pixel_rgb, bus.pixel_valid, exp_out.rgb, exp_out.valid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic show(input int h, input int v, input bit a);
        bus.hcount = 10'(h);
        bus.vcount = 10'(v);
        bus.active = a;
        tick();
        tick();
    endtask

    task automatic check_lit(input string name, input logic [11:0] rgb, input logic valid);
        total++;
        if (bus.pixel_rgb === rgb && bus.pixel_valid === valid) begin
            passes++;
        end else begin
            $display("FAIL %s: got rgb=%h valid=%b, expected rgb=%h valid=%b",
                     name, bus.pixel_rgb, bus.pixel_valid, rgb, valid);
        end
    endtask

    initial begin
        bus.display_array = '0;
        bus.gameover      = 1'b0;
        bus.frame_start   = 1'b0;
        bus.hcount        = '0;
        bus.vcount        = '0;
        bus.active        = 1'b0;
        reset             = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_lit("reset", 12'h000, 1'b0);

        bus.display_array[0] = 1'b1;
        pulse();
        show(245, 85, 1'b1);
        check_lit("top_left", 12'h0FF, 1'b1);

        bus.display_array = '0;
        bus.display_array[199] = 1'b1;
        pulse();
        show(390, 390, 1'b1);
        check_lit("bottom_right", 12'h0FF, 1'b1);
        show(384, 390, 1'b1);
        check_lit("occ_gridline", 12'h0FF, 1'b1);
        show(368, 390, 1'b1);
        check_lit("empty_gridline", 12'h333, 1'b1);

        show(239, 200, 1'b1);
        check_lit("border_left", 12'hFFF, 1'b1);
        show(400, 400, 1'b1);
        check_lit("border_corner_br", 12'hFFF, 1'b1);
        show(239, 79, 1'b1);
        check_lit("border_corner_tl", 12'hFFF, 1'b1);
        show(100, 200, 1'b1);
        check_lit("outside", 12'h000, 1'b1);
        show(245, 85, 1'b0);
        check_lit("inactive", 12'h000, 1'b0);

        bus.display_array = '0;
        pulse();
        bus.display_array[0] = 1'b1;
        show(245, 85, 1'b1);
        check_lit("snap_hold", 12'h000, 1'b1);
        tick();
        check_lit("snap_hold2", 12'h000, 1'b1);
        pulse();
        tick();
        check_lit("snap_new", 12'h0FF, 1'b1);

        // gameover rises in the same cycle as the first frame_start of the run.
        bus.gameover = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            pulse();
            tick();
            if (i == 1 || i == 31 || i == 64) check_lit($sformatf("go_red_%0d", i), 12'hF00, 1'b1);
            if (i == 32 || i == 63) check_lit($sformatf("go_hide_%0d", i), 12'h000, 1'b1);
        end
        bus.gameover = 1'b0;
        pulse();
        tick();
        check_lit("go_clear", 12'h0FF, 1'b1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_lit("reset_mid", 12'h000, 1'b0);
        show(245, 85, 1'b1);
        check_lit("post_reset_black", 12'h000, 1'b1);
        pulse();
        tick();
        check_lit("post_reset_frame", 12'h0FF, 1'b1);

        tick();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/tetris_grid_renderer.md
# tetris_grid_renderer

Downstream display stage for the Tetris game FSM. Consumes the FSM's 200-bit `display_array` and `gameover` flag and converts them into per-pixel 12-bit RGB for the VGA timing generator. It double-buffers the grid once per frame so the picture never tears, draws a border and cell gridlines, and blinks the stack after game over. It sits between `tetrisFSM` and the VGA output pins.

## Interface
Parameters:
- `H_ORIGIN`, 240: x of the grid's left pixel.
- `V_ORIGIN`, 80: y of the grid's top pixel.
- `CELL_LOG2`, 4: log2 of the cell size in pixels. Default 16 px cells give a 160×320 px grid.

Ports:
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: synchronous, active-high.
- `display_array`, in, 200: grid, bit `row*10+col`, row 0 at the top.
- `gameover`, in, 1: level from the FSM.
- `frame_start`, in, 1: one-cycle pulse, asserted only during vertical blanking.
- `hcount`, in, 10: current pixel x.
- `vcount`, in, 10: current pixel y.
- `active`, in, 1: pixel is inside the visible area.
- `pixel_rgb`, out, 12: {R4,G4,B4}.
- `pixel_valid`, out, 1: `active` delayed to match `pixel_rgb`.

## Operation
- **Snapshot.** On a `frame_start` cycle, `snap <= display_array` and `go_snap <= gameover`. Otherwise both hold.
- **Blink counter.** `blink_cnt` is 6 bits.
  - At `frame_start` with `gameover=1`: `blink_cnt <= blink_cnt+1`, wrapping 63 to 0.
  - At `frame_start` with `gameover=0`: `blink_cnt <= 0`.
  - `hide = go_snap & blink_cnt[5]`.
- **Stage 1 (registered).**
  - `dx = hcount-H_ORIGIN` and `dy = vcount-V_ORIGIN`, computed at 11 bits signed.
  - `in_grid`: 0≤dx<10·2^CELL_LOG2 and 0≤dy<20·2^CELL_LOG2.
  - `border`: the 1-px ring outside the grid, i.e. dx∈{-1, 10·cell} with dy∈[-1, 20·cell], or dy∈{-1, 20·cell} with dx∈[-1, 10·cell].
  - `col = dx>>CELL_LOG2` (4 bits), `row = dy>>CELL_LOG2` (5 bits).
  - `gridline`: the low CELL_LOG2 bits of dx or of dy are zero.
  - `active` is registered alongside.
- **Stage 2 (registered).**
  - `occ = snap[row*10+col]`. The index math uses 8 bits and is only evaluated when `in_grid`.
  - Colour priority:
    1. not active: 0x000
    2. border: 0xFFF
    3. in_grid & occ & !hide: 0xF00 if go_snap, else 0x0FF
    4. in_grid & gridline: 0x333
    5. otherwise: 0x000
  - An occupied cell's gridline pixels take the cell colour (priority 3 wins).
- **Reset values.** `snap`, `go_snap`, `blink_cnt`, both pipeline stages, `pixel_rgb` and `pixel_valid` are all 0 on the cycle after `reset` is sampled high.
- **Reset mid-frame.** Output is black until the first `frame_start` after reset, because `snap` is 0.

## Timing
- Latency is exactly 2 cycles from `hcount`/`vcount`/`active` to `pixel_rgb`/`pixel_valid`. Throughput is 1 pixel per cycle.
- `snap` changes only on the edge ending a `frame_start` cycle. Pixels whose stage-2 cycle is after that edge use the new snapshot.
- `display_array` changes mid-frame are not visible until the next `frame_start`.
- The blink phase toggles every 32 frames (about 0.53 s at 60 Hz).
- `frame_start` and `gameover` changing in the same cycle: the new `gameover` value is captured.

## Structure
- A shared package `tetris_pkg` holds:
  - `GRID_W=10`, `GRID_H=20`
  - `COL_CYAN=12'h0FF`, `COL_RED=12'hF00`, `COL_GRID=12'h333`, `COL_BORDER=12'hFFF`, `COL_BLACK=12'h000`
- Single module; no sub-module needed.

## Test plan
- **Top-left cell.** `display_array[0]=1`, pulse `frame_start`, then drive h=245, v=85, active=1 → 2 cycles later `pixel_rgb=0x0FF`, `pixel_valid=1`.
- **Bottom-right cell.** `display_array[199]=1`, pulse `frame_start`; h=390, v=390 → 0x0FF. Then h=384, v=390 (gridline of an occupied cell) → 0x0FF. Then with bit 198 clear, h=368, v=390 → 0x333.
- **Border and outside.** h=239, v=200 → 0xFFF. h=400, v=400 → 0xFFF. h=100, v=200 → 0x000. active=0 at h=245, v=85 → 0x000 with `pixel_valid=0`.
- **Snapshot isolation.** Set bit 0 after `frame_start` → h=245, v=85 stays 0x000 until the next `frame_start`, then shows 0x0FF.
- **Game-over blink.** `gameover=1`, bit 0 set. Over frames 1–31 the pixel at h=245, v=85 is 0xF00. After 32 `frame_start` pulses it is 0x000. After 64 pulses it is 0xF00 again. Drop `gameover` and pulse `frame_start` → 0x0FF with `blink_cnt=0`.
- **Reset mid-stream.** Assert `reset` for 1 cycle while rendering an occupied cell → `pixel_rgb=0`, `pixel_valid=0` next cycle. The cell stays 0x000 until a new `frame_start`.
